// File: rtl/ysyx_23060201_lsu.sv
// Load/store unit: one EXU request at a time becomes a word-aligned bus access, result returned extended.
// Minimum 3 cycles accept->resp_valid (illegal requests answer in 1); bus and EXU outputs held until accepted.
module ysyx_23060201_lsu #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_wen,
  input  logic [2:0]            i_req_func3,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_resp_valid,
  input  logic                  i_resp_ready,
  output logic [DATA_WIDTH-1:0] o_resp_rdata,
  output logic                  o_resp_err,
  output logic                  o_bus_valid,
  input  logic                  i_bus_ready,
  output logic                  o_bus_wen,
  output logic [ADDR_WIDTH-1:0] o_bus_addr,
  output logic [DATA_WIDTH-1:0] o_bus_wdata,
  output logic [3:0]            o_bus_wmask,
  input  logic                  i_bus_rsp_valid,
  input  logic [DATA_WIDTH-1:0] i_bus_rdata,
  input  logic                  i_bus_rsp_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t                r_state;
  logic [2:0]            r_func3;
  logic [1:0]            r_off;
  logic                  r_bus_wen;
  logic [ADDR_WIDTH-1:0] r_bus_addr;
  logic [DATA_WIDTH-1:0] r_bus_wdata;
  logic [3:0]            r_bus_wmask;
  logic [DATA_WIDTH-1:0] r_resp_rdata;
  logic                  r_resp_err;

  logic                  w_bad_func3;
  logic                  w_misalign;
  logic [3:0]            w_wmask;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_shift;
  logic [DATA_WIDTH-1:0] w_load_data;

  // func3[1:0] encodes access size for both loads and stores (0=byte, 1=half, 2=word)
  always_comb begin
    w_bad_func3 = i_req_wen ? (i_req_func3[2] || (i_req_func3[1:0] == 2'd3))
                            : ((i_req_func3 == 3'd3) || (i_req_func3 == 3'd6) || (i_req_func3 == 3'd7));
    w_misalign  = ((i_req_func3[1:0] == 2'd1) && i_req_addr[0]) ||
                  ((i_req_func3[1:0] == 2'd2) && (i_req_addr[1:0] != 2'd0));
    case (i_req_func3[1:0])
      2'd0: begin
        w_wmask = 4'b0001 << i_req_addr[1:0];
        w_wdata = {4{i_req_wdata[7:0]}};
      end
      2'd1: begin
        w_wmask = 4'b0011 << i_req_addr[1:0];
        w_wdata = {2{i_req_wdata[15:0]}};
      end
      default: begin
        w_wmask = 4'b1111;
        w_wdata = i_req_wdata;
      end
    endcase
  end

  always_comb begin
    w_shift = i_bus_rdata >> {r_off, 3'b000};
    case (r_func3)
      3'd0:    w_load_data = {{(DATA_WIDTH-8){w_shift[7]}}, w_shift[7:0]};
      3'd1:    w_load_data = {{(DATA_WIDTH-16){w_shift[15]}}, w_shift[15:0]};
      3'd4:    w_load_data = {{(DATA_WIDTH-8){1'b0}}, w_shift[7:0]};
      3'd5:    w_load_data = {{(DATA_WIDTH-16){1'b0}}, w_shift[15:0]};
      default: w_load_data = w_shift;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_func3      <= 3'd0;
      r_off        <= 2'd0;
      r_bus_wen    <= 1'b0;
      r_bus_addr   <= '0;
      r_bus_wdata  <= '0;
      r_bus_wmask  <= 4'd0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_func3      <= i_req_func3;
            r_off        <= i_req_addr[1:0];
            r_resp_rdata <= '0;
            if (w_bad_func3 || w_misalign) begin
              r_resp_err <= 1'b1;
              r_state    <= S_RESP;
            end else begin
              r_resp_err  <= 1'b0;
              r_bus_wen   <= i_req_wen;
              r_bus_addr  <= {i_req_addr[ADDR_WIDTH-1:2], 2'b00};
              r_bus_wmask <= i_req_wen ? w_wmask : 4'd0;
              r_bus_wdata <= i_req_wen ? w_wdata : '0;
              r_state     <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (i_bus_ready) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (i_bus_rsp_valid) begin
            r_resp_err   <= i_bus_rsp_err;
            r_resp_rdata <= (i_bus_rsp_err || r_bus_wen) ? '0 : w_load_data;
            r_state      <= S_RESP;
          end
        end
        default: begin
          if (i_resp_ready) r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_req_ready  = (r_state == S_IDLE);
  assign o_bus_valid  = (r_state == S_REQ);
  assign o_resp_valid = (r_state == S_RESP);
  assign o_bus_wen    = r_bus_wen;
  assign o_bus_addr   = r_bus_addr;
  assign o_bus_wdata  = r_bus_wdata;
  assign o_bus_wmask  = r_bus_wmask;
  assign o_resp_rdata = r_resp_rdata;
  assign o_resp_err   = r_resp_err;

endmodule

// File: tb/tb_ysyx_23060201_lsu.sv
// Directed bench for ysyx_23060201_lsu: loads, stores, illegal requests, back-pressure, reset.
module tb_ysyx_23060201_lsu;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [2:0]  req_func3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        bus_valid;
  logic        bus_ready;
  logic        bus_wen;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wmask;
  logic        bus_rsp_valid;
  logic [31:0] bus_rdata;
  logic        bus_rsp_err;

  int checks = 0;
  int errors = 0;

  ysyx_23060201_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_req_valid(req_valid),
    .o_req_ready(req_ready),
    .i_req_wen(req_wen),
    .i_req_func3(req_func3),
    .i_req_addr(req_addr),
    .i_req_wdata(req_wdata),
    .o_resp_valid(resp_valid),
    .i_resp_ready(resp_ready),
    .o_resp_rdata(resp_rdata),
    .o_resp_err(resp_err),
    .o_bus_valid(bus_valid),
    .i_bus_ready(bus_ready),
    .o_bus_wen(bus_wen),
    .o_bus_addr(bus_addr),
    .o_bus_wdata(bus_wdata),
    .o_bus_wmask(bus_wmask),
    .i_bus_rsp_valid(bus_rsp_valid),
    .i_bus_rdata(bus_rdata),
    .i_bus_rsp_err(bus_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string pfx);
    check({pfx, " req_ready"},  {31'd0, req_ready},  32'd1);
    check({pfx, " resp_valid"}, {31'd0, resp_valid}, 32'd0);
    check({pfx, " resp_err"},   {31'd0, resp_err},   32'd0);
    check({pfx, " resp_rdata"}, resp_rdata,          32'd0);
    check({pfx, " bus_valid"},  {31'd0, bus_valid},  32'd0);
    check({pfx, " bus_wen"},    {31'd0, bus_wen},    32'd0);
    check({pfx, " bus_addr"},   bus_addr,            32'd0);
    check({pfx, " bus_wdata"},  bus_wdata,           32'd0);
    check({pfx, " bus_wmask"},  {28'd0, bus_wmask},  32'd0);
  endtask

  // Presents a request for one cycle; returns in cycle 1 after acceptance.
  task automatic do_req(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata);
    req_valid = 1'b1;
    req_wen   = wen;
    req_func3 = f3;
    req_addr  = addr;
    req_wdata = wdata;
    tick();
    req_valid = 1'b0;
    req_wen   = 1'b0;
    req_func3 = 3'd0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
  endtask

  // Called in REQ with bus_ready=1: moves to WAIT, answers, returns in RESP.
  task automatic bus_answer(input logic [31:0] rdata, input logic err);
    tick();
    bus_rsp_valid = 1'b1;
    bus_rdata     = rdata;
    bus_rsp_err   = err;
    tick();
    bus_rsp_valid = 1'b0;
    bus_rdata     = 32'd0;
    bus_rsp_err   = 1'b0;
  endtask

  task automatic finish_resp(input string pfx);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check({pfx, " resp_valid cleared"}, {31'd0, resp_valid}, 32'd0);
    check({pfx, " req_ready back"},     {31'd0, req_ready},  32'd1);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_wen = 1'b0; req_func3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    resp_ready = 1'b0; bus_ready = 1'b1; bus_rsp_valid = 1'b0; bus_rdata = 32'd0; bus_rsp_err = 1'b0;
    tick();
    tick();
    check_reset_state("reset");
    rst = 1'b0;
    tick();

    // LB from byte 3, bus ready at once: resp 3 cycles after accept
    do_req(1'b0, 3'd0, 32'h8000_0003, 32'd0);
    check("lb bus_valid c1", {31'd0, bus_valid}, 32'd1);
    check("lb req_ready c1", {31'd0, req_ready}, 32'd0);
    check("lb bus_addr",     bus_addr,           32'h8000_0000);
    check("lb bus_wmask",    {28'd0, bus_wmask}, 32'd0);
    check("lb bus_wen",      {31'd0, bus_wen},   32'd0);
    tick();
    check("lb bus_valid c2", {31'd0, bus_valid},  32'd0);
    check("lb resp_valid c2", {31'd0, resp_valid}, 32'd0);
    bus_rsp_valid = 1'b1; bus_rdata = 32'h80FF_1234;
    tick();
    bus_rsp_valid = 1'b0; bus_rdata = 32'd0;
    check("lb resp_valid c3", {31'd0, resp_valid}, 32'd1);
    check("lb resp_rdata",    resp_rdata,          32'hFFFF_FF80);
    check("lb resp_err",      {31'd0, resp_err},   32'd0);
    finish_resp("lb");

    // LHU with bus_ready withheld for 4 cycles
    bus_ready = 1'b0;
    do_req(1'b0, 3'd5, 32'h8000_0002, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("lhu hold bus_valid", {31'd0, bus_valid}, 32'd1);
      check("lhu hold bus_addr",  bus_addr,           32'h8000_0000);
      check("lhu hold bus_wmask", {28'd0, bus_wmask}, 32'd0);
      tick();
    end
    check("lhu still bus_valid", {31'd0, bus_valid}, 32'd1);
    bus_ready = 1'b1;
    bus_answer(32'hBEEF_0000, 1'b0);
    check("lhu resp_valid", {31'd0, resp_valid}, 32'd1);
    check("lhu resp_rdata", resp_rdata,          32'h0000_BEEF);
    check("lhu resp_err",   {31'd0, resp_err},   32'd0);
    finish_resp("lhu");

    // Store lanes
    do_req(1'b1, 3'd0, 32'h8000_0001, 32'h1234_56AB);
    check("sb bus_wen",   {31'd0, bus_wen},   32'd1);
    check("sb bus_addr",  bus_addr,           32'h8000_0000);
    check("sb bus_wmask", {28'd0, bus_wmask}, 32'h2);
    check("sb bus_wdata", bus_wdata,          32'hABAB_ABAB);
    bus_answer(32'hDEAD_BEEF, 1'b0);
    check("sb resp_rdata", resp_rdata,        32'd0);
    check("sb resp_err",   {31'd0, resp_err}, 32'd0);
    finish_resp("sb");

    do_req(1'b1, 3'd1, 32'h8000_0002, 32'h1234_56AB);
    check("sh bus_wmask", {28'd0, bus_wmask}, 32'hC);
    check("sh bus_wdata", bus_wdata,          32'h56AB_56AB);
    bus_answer(32'hDEAD_BEEF, 1'b0);
    check("sh resp_rdata", resp_rdata,        32'd0);
    check("sh resp_err",   {31'd0, resp_err}, 32'd0);
    finish_resp("sh");

    do_req(1'b1, 3'd2, 32'h8000_0004, 32'hCAFE_F00D);
    check("sw bus_addr",  bus_addr,           32'h8000_0004);
    check("sw bus_wmask", {28'd0, bus_wmask}, 32'hF);
    check("sw bus_wdata", bus_wdata,          32'hCAFE_F00D);
    bus_answer(32'hDEAD_BEEF, 1'b0);
    check("sw resp_rdata", resp_rdata,        32'd0);
    check("sw resp_err",   {31'd0, resp_err}, 32'd0);
    finish_resp("sw");

    // Illegal requests answer in cycle 1 without the bus
    do_req(1'b0, 3'd2, 32'h8000_0002, 32'd0);
    check("lw misalign resp_valid", {31'd0, resp_valid}, 32'd1);
    check("lw misalign resp_err",   {31'd0, resp_err},   32'd1);
    check("lw misalign resp_rdata", resp_rdata,          32'd0);
    check("lw misalign bus_valid",  {31'd0, bus_valid},  32'd0);
    finish_resp("lw misalign");

    do_req(1'b0, 3'd3, 32'h8000_0000, 32'd0);
    check("func3=3 resp_valid", {31'd0, resp_valid}, 32'd1);
    check("func3=3 resp_err",   {31'd0, resp_err},   32'd1);
    check("func3=3 bus_valid",  {31'd0, bus_valid},  32'd0);
    finish_resp("func3=3");

    do_req(1'b0, 3'd2, 32'h8000_0000, 32'd0);
    check("buserr bus_valid", {31'd0, bus_valid}, 32'd1);
    bus_answer(32'h1234_5678, 1'b1);
    check("buserr resp_valid", {31'd0, resp_valid}, 32'd1);
    check("buserr resp_err",   {31'd0, resp_err},   32'd1);
    check("buserr resp_rdata", resp_rdata,          32'd0);
    finish_resp("buserr");

    // Reset while waiting on the bus
    do_req(1'b1, 3'd2, 32'h8000_0008, 32'h55AA_55AA);
    check("rstwait bus_wmask", {28'd0, bus_wmask}, 32'hF);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_state("rst in wait");

    // Response held under resp_ready=0; stray bus responses ignored
    do_req(1'b0, 3'd1, 32'h8000_0000, 32'd0);
    bus_answer(32'h0000_8001, 1'b0);
    bus_rsp_valid = 1'b1; bus_rdata = 32'h1234_5678; bus_rsp_err = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("hold resp_valid", {31'd0, resp_valid}, 32'd1);
      check("hold resp_rdata", resp_rdata,          32'hFFFF_8001);
      check("hold resp_err",   {31'd0, resp_err},   32'd0);
      check("hold req_ready",  {31'd0, req_ready},  32'd0);
      tick();
    end
    bus_rsp_valid = 1'b0; bus_rdata = 32'd0; bus_rsp_err = 1'b0;
    finish_resp("hold");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_23060201_lsu.md
# ysyx_23060201_lsu

Multi-cycle load/store unit between the execute stage and the data-memory bus of the ysyx_23060201 core. It accepts one memory request at a time from the EXU over a valid/ready handshake. It converts the request to a word-aligned bus transaction with byte strobes, waits for the bus response, and returns sign- or zero-extended load data, or a store completion, to the EXU. Misaligned or illegal requests are rejected without touching the bus.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data width; only 32 is supported

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  EXU presents a request
- req_ready  out  1  LSU can accept a request; high only in IDLE
- req_wen  in  1  1 = store, 0 = load
- req_func3  in  3  RV32I funct3: loads LB=0, LH=1, LW=2, LBU=4, LHU=5; stores SB=0, SH=1, SW=2
- req_addr  in  ADDR_WIDTH  byte address, already computed by EXU
- req_wdata  in  DATA_WIDTH  store data, right-aligned (rs2)
- resp_valid  out  1  result available; held until resp_ready
- resp_ready  in  1  EXU accepts the result
- resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned address, illegal funct3, or bus error
- bus_valid  out  1  bus request valid; held until bus_ready
- bus_ready  in  1  bus accepts the request
- bus_wen  out  1  bus write
- bus_addr  out  ADDR_WIDTH  {req_addr[31:2], 2'b00}
- bus_wdata  out  DATA_WIDTH  lane-replicated store data
- bus_wmask  out  4  byte strobes; 0 for reads
- bus_rsp_valid  in  1  single-cycle bus response strobe
- bus_rdata  in  DATA_WIDTH  full read word
- bus_rsp_err  in  1  bus error, qualified by bus_rsp_valid

## Operation
- The FSM has four states: IDLE, REQ, WAIT, RESP.
- **IDLE**
  - req_ready=1.
  - On req_valid: latch wen, func3, addr and wdata.
  - Legal request: go to REQ.
  - Illegal request: go to RESP with err=1.
- **Illegal requests**
  - Load func3 in {3,6,7}, or store func3 ≥3.
  - LH/LHU/SH with addr[0]=1.
  - LW/SW with addr[1:0]≠0.
- **REQ**
  - bus_valid=1, with bus_* driven from the latched registers only.
  - On bus_ready: go to WAIT.
- **WAIT**
  - On bus_rsp_valid: capture the extended data, or the error, into the result registers; go to RESP.
  - bus_rsp_valid is ignored in every state other than WAIT.
- **RESP**
  - resp_valid=1.
  - On resp_ready: go to IDLE.
  - A new request is accepted no earlier than the following cycle.
- **Store lanes** (o = addr[1:0])
  - SB: wmask=4'b0001<<o, wdata={4{wdata[7:0]}}.
  - SH: wmask=4'b0011<<o, wdata={2{wdata[15:0]}}.
  - SW: wmask=4'b1111, wdata=wdata.
- **Load extract**
  - s = bus_rdata >> (8*o).
  - LB: sext(s[7:0]); LBU: zext(s[7:0]).
  - LH: sext(s[15:0]); LHU: zext(s[15:0]).
  - LW: s.
- **Errors**
  - Any error forces resp_rdata=0 and resp_err=1.
  - A store completes with resp_rdata=0.

## Timing
- **Reset values:** state=IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, bus_valid=0, bus_wen=0, bus_addr=0, bus_wdata=0, bus_wmask=0.
- **Reset mid-operation:** rst in any state returns to IDLE at the next edge, and any outstanding bus transaction is abandoned. The bus is reset by the same rst.
- **Cycle numbering:** request accepted at edge of cycle 0.
  - bus_valid rises in cycle 1.
  - If bus_ready is high in cycle 1, WAIT is entered in cycle 2.
  - bus_rsp_valid in cycle k causes resp_valid in cycle k+1.
- **Minimum latency:** accept→resp_valid is 3 cycles.
- **Illegal request:** resp_valid in cycle 1; the bus is never asserted.
- **Stability:** bus_* outputs are stable while bus_valid=1 and bus_ready=0. resp_* outputs are stable while resp_valid=1 and resp_ready=0.
- **Outputs:** all outputs are registered, or decoded from state only. There is no combinational path from any input to any output.
- **Throughput:** at most one request is in flight; no pipelining.

## Test plan
- **Signed byte load.** LB, addr=0x80000003, bus_rdata=0x80FF_1234, bus_ready and bus_rsp_valid immediate → bus_addr=0x80000000, bus_wmask=0, resp_rdata=0xFFFF_FF80, resp_err=0, resp_valid 3 cycles after accept.
- **Unsigned halfword load with back-pressure.** LHU, addr=0x80000002, bus_rdata=0xBEEF_0000, bus_ready delayed 4 cycles → bus outputs held stable while waiting; resp_rdata=0x0000_BEEF.
- **Store lanes.**
  - SB addr=0x80000001 wdata=0x1234_56AB → bus_wmask=4'b0010, bus_wdata=0xABAB_ABAB.
  - SH addr=0x80000002 → bus_wmask=4'b1100.
  - SW → 4'b1111.
  - Each completes with resp_rdata=0, resp_err=0.
- **Illegal requests.**
  - LW addr=0x80000002 → resp_err=1 in cycle 1, bus_valid never asserted.
  - Load func3=3 → same.
  - Bus response with bus_rsp_err=1 → resp_err=1, resp_rdata=0.
- **Reset and response hold.**
  - Assert rst while in WAIT → all outputs return to their reset values next cycle, and req_ready=1.
  - Hold resp_ready=0 for 5 cycles → resp_valid and resp_rdata stay stable, and req_ready stays 0.
